// File: rtl/trace_pkg.sv
// Shared types for the architectural commit trace: record classes, record payload, unit state.
package trace_pkg;

   localparam logic [2:0] TR_NOP   = 3'd0;
   localparam logic [2:0] TR_REG   = 3'd1;
   localparam logic [2:0] TR_LOAD  = 3'd2;
   localparam logic [2:0] TR_STORE = 3'd3;
   localparam logic [2:0] TR_HALT  = 3'd4;

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] pc;
      logic [3:0]  rd;
      logic [15:0] value;
      logic [15:0] addr;
   } trace_rec_t;

   localparam int unsigned REC_W = $bits(trace_rec_t);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } trace_state_e;

   // First match wins: a load also writes a register, so it must be tested before REG.
   function automatic logic [2:0] classify(input logic reg_write, input logic mem_read,
                                           input logic mem_write, input logic halt);
      logic [2:0] kind;
      kind = TR_NOP;
      if (reg_write && mem_read) kind = TR_LOAD;
      else if (reg_write)        kind = TR_REG;
      else if (halt)             kind = TR_HALT;
      else if (mem_write)        kind = TR_STORE;
      return kind;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is readable whenever not empty.
module trace_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/commit_trace_unit.sv
// Builds one trace record per retired instruction, buffers it, and streams it out over valid/ready.
module commit_trace_unit
   import trace_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             commit_valid,
   input  logic [15:0]      commit_pc,
   input  logic [15:0]      commit_inst,
   input  logic             reg_write,
   input  logic [3:0]       write_reg,
   input  logic [15:0]      write_data,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [15:0]      mem_addr,
   input  logic [15:0]      mem_data,
   input  logic             halt,
   output logic             cpu_stall,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [2:0]       trace_type,
   output logic [CNT_W-1:0] trace_inum,
   output logic [15:0]      trace_pc,
   output logic [3:0]       trace_reg,
   output logic [15:0]      trace_value,
   output logic [15:0]      trace_addr,
   output logic             overflow,
   output logic             trace_done
);

   localparam int unsigned ENT_W = REC_W + CNT_W;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   trace_state_e     state;
   logic [CNT_W-1:0] inum;
   trace_rec_t       rec_in;
   trace_rec_t       rec_out;
   logic [ENT_W-1:0] fifo_wdata;
   logic [ENT_W-1:0] fifo_rdata;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
   logic             push;
   logic             pop;
   logic             inst_unused;

   // The instruction word is not carried in the record; the port keeps parity with the sim trace.
   assign inst_unused = ^commit_inst;

   always_comb begin
      rec_in      = '0;
      rec_in.kind = classify(reg_write, mem_read, mem_write, halt);
      rec_in.pc   = commit_pc;
      case (rec_in.kind)
         TR_REG: begin
            rec_in.rd    = write_reg;
            rec_in.value = write_data;
         end
         TR_LOAD: begin
            rec_in.rd    = write_reg;
            rec_in.value = write_data;
            rec_in.addr  = mem_addr;
         end
         TR_STORE: begin
            rec_in.value = mem_data;
            rec_in.addr  = mem_addr;
         end
         default: ;
      endcase
   end

   assign pop        = !empty && trace_ready;
   assign push       = commit_valid && (state == RUN) && (!full || pop);
   assign fifo_wdata = {inum, rec_in};

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign rec_out     = trace_rec_t'(fifo_rdata[REC_W-1:0]);
   assign trace_valid = !empty;
   assign cpu_stall   = (state == RUN) ? full : 1'b1;
   assign trace_done  = (state == DONE);

   // Fields are forced to zero while nothing is queued so a stale entry is never shown.
   always_comb begin
      trace_type  = '0;
      trace_inum  = '0;
      trace_pc    = '0;
      trace_reg   = '0;
      trace_value = '0;
      trace_addr  = '0;
      if (trace_valid) begin
         trace_type  = rec_out.kind;
         trace_inum  = fifo_rdata[ENT_W-1:REC_W];
         trace_pc    = rec_out.pc;
         trace_reg   = rec_out.rd;
         trace_value = rec_out.value;
         trace_addr  = rec_out.addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         inum     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) inum <= inum + CNT_W'(1);
         if (commit_valid && (state == RUN) && full && !pop) overflow <= 1'b1;
         case (state)
            RUN:     if (push && (rec_in.kind == TR_HALT)) state <= DRAIN;
            DRAIN:   if (pop && (count == CW'(1)))         state <= DONE;
            DONE:    state <= DONE;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed self-checking bench for commit_trace_unit (DEPTH=8, CNT_W=4 so the counter wrap is reachable).
module tb_commit_trace_unit;

   logic        clk;
   logic        rst_n;
   logic        commit_valid;
   logic [15:0] commit_pc;
   logic [15:0] commit_inst;
   logic        reg_write;
   logic [3:0]  write_reg;
   logic [15:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        halt;
   logic        cpu_stall;
   logic        trace_valid;
   logic        trace_ready;
   logic [2:0]  trace_type;
   logic [3:0]  trace_inum;
   logic [15:0] trace_pc;
   logic [3:0]  trace_reg;
   logic [15:0] trace_value;
   logic [15:0] trace_addr;
   logic        overflow;
   logic        trace_done;

   int n_cmp;
   int n_err;

   commit_trace_unit #(
      .DEPTH (8),
      .CNT_W (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .commit_inst  (commit_inst),
      .reg_write    (reg_write),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .halt         (halt),
      .cpu_stall    (cpu_stall),
      .trace_valid  (trace_valid),
      .trace_ready  (trace_ready),
      .trace_type   (trace_type),
      .trace_inum   (trace_inum),
      .trace_pc     (trace_pc),
      .trace_reg    (trace_reg),
      .trace_value  (trace_value),
      .trace_addr   (trace_addr),
      .overflow     (overflow),
      .trace_done   (trace_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_rec(input string tag, input logic [2:0] kind, input logic [3:0] num,
                          input logic [15:0] pc, input logic [3:0] rd,
                          input logic [15:0] val, input logic [15:0] addr);
      check({tag, ".valid"}, 32'(trace_valid), 32'd1);
      check({tag, ".type"},  32'(trace_type),  32'(kind));
      check({tag, ".inum"},  32'(trace_inum),  32'(num));
      check({tag, ".pc"},    32'(trace_pc),    32'(pc));
      check({tag, ".reg"},   32'(trace_reg),   32'(rd));
      check({tag, ".value"}, 32'(trace_value), 32'(val));
      check({tag, ".addr"},  32'(trace_addr),  32'(addr));
   endtask

   // kind: 0 NOP, 1 REG, 2 LOAD, 3 STORE, 4 HALT; write_data/mem_data differ so the wrong source shows.
   task automatic commit(input logic [2:0] kind, input logic [15:0] pc, input logic [3:0] rd,
                         input logic [15:0] val, input logic [15:0] addr);
      commit_valid = 1'b1;
      commit_pc    = pc;
      commit_inst  = {kind, 13'h0A5};
      reg_write    = (kind == 3'd1) || (kind == 3'd2);
      mem_read     = (kind == 3'd2);
      mem_write    = (kind == 3'd3);
      halt         = (kind == 3'd4);
      write_reg    = rd;
      write_data   = (kind == 3'd3) ? ~val : val;
      mem_data     = (kind == 3'd3) ? val : ~val;
      mem_addr     = addr;
   endtask

   task automatic idle();
      commit_valid = 1'b0;
      commit_pc    = '0;
      commit_inst  = '0;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      halt         = 1'b0;
      write_reg    = '0;
      write_data   = '0;
      mem_data     = '0;
      mem_addr     = '0;
   endtask

   task automatic do_reset();
      tick();
      idle();
      trace_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst.valid",    32'(trace_valid), 32'd0);
      check("rst.stall",    32'(cpu_stall),   32'd0);
      check("rst.overflow", 32'(overflow),    32'd0);
      check("rst.done",     32'(trace_done),  32'd0);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      trace_ready = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;

      // Reset mid-stream with three records queued.
      for (int i = 0; i < 3; i++) begin
         commit(3'd1, 16'(2 * i), 4'd1, 16'h0011, 16'h0);
         tick();
      end
      idle();
      check("pre_rst.valid", 32'(trace_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.valid", 32'(trace_valid), 32'd0);
      check("midrst.type",  32'(trace_type),  32'd0);
      check("midrst.pc",    32'(trace_pc),    32'd0);
      check("midrst.reg",   32'(trace_reg),   32'd0);
      check("midrst.value", 32'(trace_value), 32'd0);
      check("midrst.stall", 32'(cpu_stall),   32'd0);
      tick();
      rst_n = 1'b1;
      commit(3'd0, 16'h0030, 4'd0, 16'h0, 16'h0);
      tick();
      idle();
      chk_rec("post_rst", 3'd0, 4'd0, 16'h0030, 4'd0, 16'h0, 16'h0);

      // Mixed classification with the consumer always ready.
      do_reset();
      trace_ready = 1'b1;
      commit(3'd1, 16'h0000, 4'd3, 16'h0005, 16'h9999);
      tick();
      chk_rec("add", 3'd1, 4'd0, 16'h0000, 4'd3, 16'h0005, 16'h0000);
      commit(3'd2, 16'h0002, 4'd4, 16'h1234, 16'h0040);
      tick();
      chk_rec("lw", 3'd2, 4'd1, 16'h0002, 4'd4, 16'h1234, 16'h0040);
      commit(3'd3, 16'h0004, 4'd7, 16'hBEEF, 16'h0042);
      tick();
      chk_rec("sw", 3'd3, 4'd2, 16'h0004, 4'd0, 16'hBEEF, 16'h0042);
      commit(3'd0, 16'h0006, 4'd5, 16'h7777, 16'h8888);
      tick();
      chk_rec("br", 3'd0, 4'd3, 16'h0006, 4'd0, 16'h0000, 16'h0000);
      idle();
      tick();
      check("mix.empty", 32'(trace_valid), 32'd0);

      // Backpressure: fill, overflow on a stalled commit, then drain in order.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("bp.stall_before8", 32'(cpu_stall), 32'd0);
         commit(3'd0, 16'(16'h0100 + 16'(2 * i)), 4'd0, 16'h0, 16'h0);
         tick();
      end
      check("bp.stall_full", 32'(cpu_stall), 32'd1);
      check("bp.ovf_before", 32'(overflow),  32'd0);
      commit(3'd0, 16'h0110, 4'd0, 16'h0, 16'h0);
      tick();
      idle();
      check("bp.ovf_set", 32'(overflow), 32'd1);
      trace_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("bp.drain_valid", 32'(trace_valid), 32'd1);
         check("bp.drain_inum",  32'(trace_inum),  32'(i));
         check("bp.drain_pc",    32'(trace_pc),    32'(16'h0100 + 16'(2 * i)));
         tick();
      end
      check("bp.no_inum8",   32'(trace_valid), 32'd0);
      check("bp.ovf_sticky", 32'(overflow),    32'd1);
      check("bp.stall_free", 32'(cpu_stall),   32'd0);

      // Push and pop together while full: no drop, occupancy unchanged.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         commit(3'd0, 16'(2 * i), 4'd0, 16'h0, 16'h0);
         tick();
      end
      trace_ready = 1'b1;
      commit(3'd1, 16'h0200, 4'd9, 16'h00AA, 16'h0);
      check("pp.stall_pre", 32'(cpu_stall), 32'd1);
      tick();
      idle();
      trace_ready = 1'b0;
      check("pp.ovf",        32'(overflow),   32'd0);
      check("pp.still_full", 32'(cpu_stall),  32'd1);
      check("pp.head",       32'(trace_inum), 32'd1);
      trace_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         check("pp.drain_inum", 32'(trace_inum), 32'(i));
         tick();
      end
      chk_rec("pp.last", 3'd1, 4'd8, 16'h0200, 4'd9, 16'h00AA, 16'h0);
      tick();
      check("pp.empty", 32'(trace_valid), 32'd0);

      // Halt drain: later commits are ignored, done after the halt record leaves.
      do_reset();
      commit(3'd0, 16'h0002, 4'd0, 16'h0, 16'h0);
      tick();
      commit(3'd0, 16'h0004, 4'd0, 16'h0, 16'h0);
      tick();
      commit(3'd4, 16'h000A, 4'd0, 16'h0, 16'h0);
      tick();
      commit(3'd1, 16'h000C, 4'd2, 16'h0033, 16'h0);
      check("hlt.stall", 32'(cpu_stall),  32'd1);
      check("hlt.done0", 32'(trace_done), 32'd0);
      tick();
      tick();
      check("hlt.no_ovf", 32'(overflow), 32'd0);
      trace_ready = 1'b1;
      check("hlt.pop0", 32'(trace_inum), 32'd0);
      tick();
      check("hlt.pop1", 32'(trace_inum), 32'd1);
      tick();
      chk_rec("hlt.rec", 3'd4, 4'd2, 16'h000A, 4'd0, 16'h0, 16'h0);
      check("hlt.done_early", 32'(trace_done), 32'd0);
      tick();
      check("hlt.done",     32'(trace_done),  32'd1);
      check("hlt.empty",    32'(trace_valid), 32'd0);
      check("hlt.stall_dn", 32'(cpu_stall),   32'd1);
      tick();
      check("hlt.done_hold", 32'(trace_done), 32'd1);
      idle();

      // Counter wrap at 2^4.
      do_reset();
      trace_ready = 1'b1;
      commit(3'd0, 16'h0300, 4'd0, 16'h0, 16'h0);
      for (int i = 0; i < 17; i++) begin
         tick();
         check("wrap.inum", 32'(trace_inum), 32'(i % 16));
      end
      idle();
      tick();
      check("wrap.empty", 32'(trace_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
